// File: rtl/rx_char_fifo.sv
// ----------------------------------------------------------------------------
// rx_char_fifo
//   Receive-side character buffer sitting just downstream of the async serial
//   interface. Each rising edge of the iLoad level captures the 7-bit word iD
//   into a small FIFO. The oldest character is presented on DataOut with a
//   Valid/Read handshake, and a sticky Overrun flag records any character
//   that had to be dropped because the buffer was full.
//
// Ports
//   CLK       in   1      system clock, all state on rising edge
//   Reset     in   1      synchronous active-high reset, dominates all inputs
//   iD        in   7      parallel character from the serial interface
//   iLoad     in   1      load strobe (level); one push per rising edge
//   Read      in   1      consumer pop request, honoured only while Valid
//   ClearErr  in   1      clears the sticky Overrun flag
//   DataOut   out  7      head character, 7'h00 while Empty
//   Valid     out  1      DataOut holds a character
//   Empty     out  1      occupancy is zero
//   Full      out  1      occupancy equals DEPTH
//   Overrun   out  1      sticky: a character was dropped on a full buffer
//   Count     out  CNT_W  current occupancy
// ----------------------------------------------------------------------------
module rx_char_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [6:0]       iD,
    input  logic             iLoad,
    input  logic             Read,
    input  logic             ClearErr,
    output logic [6:0]       DataOut,
    output logic             Valid,
    output logic             Empty,
    output logic             Full,
    output logic             Overrun,
    output logic [CNT_W-1:0] Count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [6:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovr_q, ovr_d;
    logic             load_q;

    logic push, pop, wr_en, drop;
    logic empty, full;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(DEPTH));

    always_comb begin
        // Edge-detect the load level so a long strobe yields a single push.
        push  = iLoad & ~load_q;
        pop   = Read & ~empty;
        // A simultaneous pop frees the slot a full buffer needs for the write.
        wr_en = push & (~full | pop);
        drop  = push & full & ~pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);

        if (wr_en && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (pop && !wr_en) cnt_d = cnt_q - CNT_W'(1);

        // Setting on a drop takes priority over a same-cycle clear.
        if (drop)          ovr_d = 1'b1;
        else if (ClearErr) ovr_d = 1'b0;
        else               ovr_d = ovr_q;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovr_q    <= 1'b0;
            // Held high so an iLoad level present at reset release is ignored.
            load_q   <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovr_q    <= ovr_d;
            load_q   <= iLoad;
        end
    end

    // Storage is not reset; DataOut masking below hides stale contents.
    always_ff @(posedge CLK) begin
        if (!Reset && wr_en) begin
            mem_q[wr_ptr_q] <= iD;
        end
    end

    assign DataOut = empty ? 7'h00 : mem_q[rd_ptr_q];
    assign Valid   = ~empty;
    assign Empty   = empty;
    assign Full    = full;
    assign Overrun = ovr_q;
    assign Count   = cnt_q;

endmodule

// File: tb/tb_rx_char_fifo.sv
module tb_rx_char_fifo;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             CLK = 1'b0;
    logic             Reset = 1'b1;
    logic [6:0]       iD = '0;
    logic             iLoad = 1'b0;
    logic             Read = 1'b0;
    logic             ClearErr = 1'b0;
    logic [6:0]       DataOut;
    logic             Valid;
    logic             Empty;
    logic             Full;
    logic             Overrun;
    logic [CNT_W-1:0] Count;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of characters plus the overrun flag and the
    // previous iLoad level used for edge detection.
    logic [6:0] mq[$];
    bit         m_ovr  = 1'b0;
    bit         m_prev = 1'b1;

    rx_char_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .Reset(Reset), .iD(iD), .iLoad(iLoad), .Read(Read),
        .ClearErr(ClearErr), .DataOut(DataOut), .Valid(Valid), .Empty(Empty),
        .Full(Full), .Overrun(Overrun), .Count(Count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rst, input bit ld, input logic [6:0] d,
                              input bit rd, input bit clr);
        bit push, pop, was_full, dropped;
        if (rst) begin
            mq.delete();
            m_ovr  = 1'b0;
            m_prev = 1'b1;
            return;
        end
        push     = ld && !m_prev;
        pop      = rd && (mq.size() > 0);
        was_full = (mq.size() == DEPTH);
        dropped  = 1'b0;
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (!was_full || pop) mq.push_back(d);
            else dropped = 1'b1;
        end
        if (dropped) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        m_prev = ld;
    endtask

    task automatic check_all(input string tag);
        logic [6:0] exp_d;
        exp_d = (mq.size() > 0) ? mq[0] : 7'h00;
        chk({tag, ".DataOut"}, 32'(DataOut), 32'(exp_d));
        chk({tag, ".Valid"},   32'(Valid),   32'(mq.size() > 0));
        chk({tag, ".Empty"},   32'(Empty),   32'(mq.size() == 0));
        chk({tag, ".Full"},    32'(Full),    32'(mq.size() == DEPTH));
        chk({tag, ".Overrun"}, 32'(Overrun), 32'(m_ovr));
        chk({tag, ".Count"},   32'(Count),   32'(mq.size()));
    endtask

    // One clock: drive inputs, take the edge, update the model, then sample.
    task automatic step(input string tag, input bit ld, input logic [6:0] d,
                        input bit rd, input bit clr, input bit rst);
        iLoad = ld; iD = d; Read = rd; ClearErr = clr; Reset = rst;
        @(posedge CLK);
        model_edge(rst, ld, d, rd, clr);
        #1;
        check_all(tag);
    endtask

    task automatic push_char(input string tag, input logic [6:0] d);
        step(tag, 1'b1, d, 1'b0, 1'b0, 1'b0);
        step(tag, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_expect(input string tag, input logic [6:0] exp);
        chk({tag, ".head"}, 32'(DataOut), 32'(exp));
        step(tag, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // 1: iLoad held high through reset and its release -> no capture
        #1;
        step("rst", 1'b1, 7'h55, 1'b0, 1'b0, 1'b1);
        step("rst", 1'b1, 7'h55, 1'b0, 1'b0, 1'b1);
        step("rst_rel", 1'b1, 7'h55, 1'b0, 1'b0, 1'b0);
        step("rst_rel", 1'b1, 7'h55, 1'b0, 1'b0, 1'b0);
        chk("rst_rel.count_const", 32'(Count), 32'd0);
        chk("rst_rel.data_const", 32'(DataOut), 32'd0);
        step("idle", 1'b0, 7'h00, 1'b0, 1'b0, 1'b0);

        // 2: three-cycle iLoad pulse -> exactly one entry
        for (int i = 0; i < 3; i++) step("pulse3", 1'b1, 7'h41, 1'b0, 1'b0, 1'b0);
        step("pulse3", 1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        chk("pulse3.count_const", 32'(Count), 32'd1);
        chk("pulse3.valid_const", 32'(Valid), 32'd1);
        pop_expect("pulse3_pop", 7'h41);
        step("read_empty", 1'b0, 7'h00, 1'b1, 1'b0, 1'b0);

        // 3: fill, overflow drop, drain in order, clear error
        for (int i = 1; i <= 4; i++) push_char("fill", 7'(i));
        chk("fill.full_const", 32'(Full), 32'd1);
        push_char("drop", 7'h05);
        chk("drop.ovr_const", 32'(Overrun), 32'd1);
        for (int i = 1; i <= 4; i++) pop_expect("drain", 7'(i));
        chk("drain.empty_const", 32'(Empty), 32'd1);
        step("clr", 1'b0, 7'h00, 1'b0, 1'b1, 1'b0);
        chk("clr.ovr_const", 32'(Overrun), 32'd0);

        // 4: push with simultaneous pop on a full buffer
        for (int i = 1; i <= 4; i++) push_char("fill2", 7'(i));
        step("full_pp", 1'b1, 7'h7F, 1'b1, 1'b0, 1'b0);
        step("full_pp", 1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        chk("full_pp.count_const", 32'(Count), 32'd4);
        chk("full_pp.ovr_const", 32'(Overrun), 32'd0);
        pop_expect("full_pp_pop", 7'h02);
        pop_expect("full_pp_pop", 7'h03);
        pop_expect("full_pp_pop", 7'h04);
        pop_expect("full_pp_pop", 7'h7F);

        // 5: push/pop pairs walking the pointers across the wrap
        for (int i = 0; i < 6; i++) begin
            push_char("wrap", 7'(8'h10 + i));
            pop_expect("wrap_pop", 7'(8'h10 + i));
        end

        // push into empty with Read asserted: read ignored, write accepted
        step("empty_pr", 1'b1, 7'h33, 1'b1, 1'b0, 1'b0);
        chk("empty_pr.count_const", 32'(Count), 32'd1);
        step("empty_pr", 1'b0, 7'h00, 1'b0, 1'b0, 1'b0);

        // drop and ClearErr on the same edge: set wins
        for (int i = 0; i < 3; i++) push_char("fill3", 7'(8'h20 + i));
        step("drop_clr", 1'b1, 7'h6A, 1'b0, 1'b1, 1'b0);
        chk("drop_clr.ovr_const", 32'(Overrun), 32'd1);
        step("drop_clr", 1'b0, 7'h00, 1'b0, 1'b0, 1'b0);

        // 6: reset mid-operation with Read asserted
        step("rst_mid", 1'b0, 7'h00, 1'b1, 1'b0, 1'b1);
        chk("rst_mid.count_const", 32'(Count), 32'd0);
        chk("rst_mid.data_const", 32'(DataOut), 32'd0);
        step("rst_mid", 1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        push_char("pre6", 7'h0A);
        push_char("pre6", 7'h0B);
        step("rst6", 1'b0, 7'h00, 1'b1, 1'b0, 1'b1);
        chk("rst6.valid_const", 32'(Valid), 32'd0);
        step("rst6", 1'b0, 7'h00, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step("rand",
                 ($urandom_range(0, 99) < 55),
                 7'($urandom),
                 ($urandom_range(0, 99) < 35),
                 ($urandom_range(0, 99) < 8),
                 ($urandom_range(0, 99) < 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
